// File: rtl/delay_tap_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : delay_tap_mixer_pkg
// Brief    : Shared constants, FSM state type and gain-step helper for the
//            delay tap mixer.
// Revision : 1.0 - initial release
// ============================================================================
package delay_tap_mixer_pkg;

    localparam int W      = 8;                 // sample width
    localparam int GAIN_W = 4;                 // wet-gain width
    localparam int NTAP   = 4;                 // number of delay taps
    localparam int SEL_W  = 2;                 // tap-select width
    localparam int ACC_W  = W + GAIN_W + 1;    // product / sum width

    // Half an LSB of the gain denominator, for round-to-nearest.
    localparam logic [ACC_W-1:0]  C_ROUND = ACC_W'(2 ** (GAIN_W - 1));
    // Full-scale weight (2^GAIN_W); needs one more bit than the gain.
    localparam logic [GAIN_W:0]   C_UNITY = (GAIN_W + 1)'(2 ** GAIN_W);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWITCH   = 2'd2,
        ST_FADE_IN  = 2'd3
    } mix_state_e;

    // Move one step toward the target, never past it.
    function automatic logic [GAIN_W-1:0] step_toward(
        input logic [GAIN_W-1:0] cur,
        input logic [GAIN_W-1:0] tgt
    );
        if (cur < tgt) begin
            return cur + 1'b1;
        end else if (cur > tgt) begin
            return cur - 1'b1;
        end
        return cur;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_tap_mixer_if.sv
`default_nettype none
// ============================================================================
// Module   : delay_tap_mixer_if
// Brief    : Sample/control bundle between the delay lines and the mixer.
//            master = sample source, slave = mixer.
// Revision : 1.0 - initial release
// ============================================================================
interface delay_tap_mixer_if;
    import delay_tap_mixer_pkg::*;

    logic                 ena;
    logic                 sample_en;
    logic [W-1:0]         dry;
    logic [NTAP*W-1:0]    taps;
    logic [SEL_W-1:0]     tap_sel;
    logic [GAIN_W-1:0]    mix_gain;
    logic [W-1:0]         y;
    logic                 y_valid;
    logic                 busy;
    logic [SEL_W-1:0]     active_tap;

    modport master (
        output ena, sample_en, dry, taps, tap_sel, mix_gain,
        input  y, y_valid, busy, active_tap
    );

    modport slave (
        input  ena, sample_en, dry, taps, tap_sel, mix_gain,
        output y, y_valid, busy, active_tap
    );

endinterface
`default_nettype wire

// File: rtl/delay_tap_mixer_mix_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mix_mac_pipe
// Brief    : Two-stage weighted dry/wet sum. Stage 1 registers both products,
//            stage 2 registers the rounded, scaled sum and strobes y_valid.
// Revision : 1.0 - initial release
// ============================================================================
module mix_mac_pipe
    import delay_tap_mixer_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              ena,
    input  wire logic              in_valid,
    input  wire logic [W-1:0]      dry,
    input  wire logic [W-1:0]      wet,
    input  wire logic [GAIN_W-1:0] gain,
    output logic      [W-1:0]      y,
    output logic                   y_valid
);

    logic [ACC_W-1:0] dry_prod_q, dry_prod_d;
    logic [ACC_W-1:0] wet_prod_q, wet_prod_d;
    logic             v1_q, v1_d;
    logic [W-1:0]     y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [ACC_W-1:0] w_sum;

    // Next-state for both pipeline stages; disabled stage mutes the output.
    always_comb begin
        dry_prod_d = dry_prod_q;
        wet_prod_d = wet_prod_q;
        v1_d       = 1'b0;
        y_d        = y_q;
        y_valid_d  = 1'b0;
        // Sum cannot exceed (2^W-1)*2^GAIN_W + round, so ACC_W never wraps.
        w_sum      = dry_prod_q + wet_prod_q + C_ROUND;
        if (ena) begin
            if (in_valid) begin
                dry_prod_d = ACC_W'(dry) * ACC_W'(C_UNITY - {1'b0, gain});
                wet_prod_d = ACC_W'(wet) * ACC_W'(gain);
                v1_d       = 1'b1;
            end
            if (v1_q) begin
                y_d       = W'(w_sum >> GAIN_W);
                y_valid_d = 1'b1;
            end
        end else begin
            y_d = '0;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dry_prod_q <= '0;
            wet_prod_q <= '0;
            v1_q       <= 1'b0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
        end else begin
            dry_prod_q <= dry_prod_d;
            wet_prod_q <= wet_prod_d;
            v1_q       <= v1_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule
`default_nettype wire

// File: rtl/delay_tap_mixer.sv
`default_nettype none
// ============================================================================
// Module   : delay_tap_mixer
// Brief    : Dry/wet mixer over four delay taps with a glitch-free tap change:
//            wet gain ramps to zero, the tap switches, then the gain ramps back.
// Revision : 1.0 - initial release
// ============================================================================
module delay_tap_mixer
    import delay_tap_mixer_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst_n,
    delay_tap_mixer_if.slave  bus
);

    mix_state_e        state_q, state_d;
    logic [GAIN_W-1:0] eff_g_q, eff_g_d;
    logic [SEL_W-1:0]  active_tap_q, active_tap_d;
    logic [W-1:0]      w_tap [NTAP];
    logic [W-1:0]      w_wet;

    for (genvar k = 0; k < NTAP; k++) begin : g_tap_unpack
        assign w_tap[k] = bus.taps[k*W +: W];
    end

    // Only switched while eff_g is zero, so a mux change never reaches y.
    assign w_wet = w_tap[active_tap_q];

    // Crossfade sequencing and gain ramp; everything holds while disabled.
    always_comb begin
        state_d      = state_q;
        eff_g_d      = eff_g_q;
        active_tap_d = active_tap_q;
        if (bus.ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.tap_sel != active_tap_q) begin
                        state_d = ST_FADE_OUT;
                    end else if (bus.sample_en) begin
                        eff_g_d = step_toward(eff_g_q, bus.mix_gain);
                    end
                end
                ST_FADE_OUT: begin
                    if (bus.sample_en) begin
                        if (eff_g_q == '0) begin
                            state_d = ST_SWITCH;
                        end else begin
                            eff_g_d = eff_g_q - 1'b1;
                        end
                    end
                end
                ST_SWITCH: begin
                    // Latest request wins; earlier changes during the fade are dropped.
                    active_tap_d = bus.tap_sel;
                    state_d      = ST_FADE_IN;
                end
                ST_FADE_IN: begin
                    // Target is tracked live, so a lowered gain ramps down here.
                    if (eff_g_q == bus.mix_gain) begin
                        state_d = ST_IDLE;
                    end else if (bus.sample_en) begin
                        eff_g_d = step_toward(eff_g_q, bus.mix_gain);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            eff_g_q      <= '0;
            active_tap_q <= '0;
        end else begin
            state_q      <= state_d;
            eff_g_q      <= eff_g_d;
            active_tap_q <= active_tap_d;
        end
    end

    mix_mac_pipe u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (bus.ena),
        .in_valid (bus.sample_en),
        .dry      (bus.dry),
        .wet      (w_wet),
        .gain     (eff_g_q),
        .y        (bus.y),
        .y_valid  (bus.y_valid)
    );

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.active_tap = active_tap_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_tap_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_tap_mixer
// Brief    : Self-checking bench for delay_tap_mixer: behavioural model,
//            per-cycle compare, directed scenarios and a random phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_tap_mixer;
    import delay_tap_mixer_pkg::*;

    localparam int PH_IDLE = 0;
    localparam int PH_OUT  = 1;
    localparam int PH_SW   = 2;
    localparam int PH_IN   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    delay_tap_mixer_if bus ();

    delay_tap_mixer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_g     = 0;
    int m_tap   = 0;
    int m_phase = PH_IDLE;
    int m_y     = 0;
    int m_yv    = 0;
    int s1_v    = 0;
    int s1_y    = 0;
    int m_tgt   = 0;
    int m_wet   = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model: the mix formula on the sample taken at the strobe, two cycles of
    // delay, and the fade/switch/fade sequence written as plain arithmetic.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_g = 0; m_tap = 0; m_phase = PH_IDLE;
            m_y = 0; m_yv = 0; s1_v = 0; s1_y = 0;
        end else if (bus.ena) begin
            if (s1_v != 0) begin
                m_y  = s1_y;
                m_yv = 1;
            end else begin
                m_yv = 0;
            end
            s1_v = int'(bus.sample_en);
            if (bus.sample_en) begin
                m_wet = int'(bus.taps[m_tap*W +: W]);
                s1_y  = (int'(bus.dry) * ((1 << GAIN_W) - m_g) + m_wet * m_g
                         + (1 << (GAIN_W - 1))) / (1 << GAIN_W);
            end
            m_tgt = int'(bus.mix_gain);
            if (m_phase == PH_IDLE) begin
                if (int'(bus.tap_sel) != m_tap) m_phase = PH_OUT;
                else if (bus.sample_en) m_g = m_g + (m_tgt > m_g ? 1 : 0) - (m_tgt < m_g ? 1 : 0);
            end else if (m_phase == PH_OUT) begin
                if (bus.sample_en) begin
                    if (m_g == 0) m_phase = PH_SW;
                    else m_g = m_g - 1;
                end
            end else if (m_phase == PH_SW) begin
                m_tap   = int'(bus.tap_sel);
                m_phase = PH_IN;
            end else begin
                if (m_g == m_tgt) m_phase = PH_IDLE;
                else if (bus.sample_en) m_g = m_g + (m_tgt > m_g ? 1 : 0) - (m_tgt < m_g ? 1 : 0);
            end
        end else begin
            s1_v = 0; m_yv = 0; m_y = 0;
        end
    end

    // Per-cycle compare of every output against the model.
    initial forever begin
        @(negedge clk);
        check("cyc_y",          int'(bus.y),          m_y);
        check("cyc_y_valid",    int'(bus.y_valid),    m_yv);
        check("cyc_busy",       int'(bus.busy),       (m_phase != PH_IDLE) ? 1 : 0);
        check("cyc_active_tap", int'(bus.active_tap), m_tap);
    end

    // One strobe, then read the result two cycles later.
    task automatic measure(input string name, input int exp);
        bus.sample_en = 1'b1;
        tick();
        bus.sample_en = 1'b0;
        tick();
        check({name, "_dut"},   int'(bus.y),       exp);
        check({name, "_model"}, m_y,               exp);
        check({name, "_vld"},   int'(bus.y_valid), 1);
    endtask

    task automatic strobes(input int n);
        bus.sample_en = 1'b1;
        repeat (n) tick();
        bus.sample_en = 1'b0;
    endtask

    // Random strobes until the crossfade finishes; counts busy rising edges.
    task automatic run_fade(input string name, input int alt_at, input int alt_sel,
                            output int rises);
        int prev;
        int done;
        prev  = int'(bus.busy);
        rises = 0;
        done  = 0;
        for (int i = 0; i < 400; i++) begin
            if (i == alt_at) bus.tap_sel = 2'(alt_sel);
            bus.sample_en = 1'(($urandom % 3) != 0);
            tick();
            if (bus.busy && prev == 0) rises++;
            prev = int'(bus.busy);
            if (i > 0 && m_phase == PH_IDLE && !bus.busy) begin
                done = 1;
                break;
            end
        end
        bus.sample_en = 1'b0;
        check({name, "_finished"}, done, 1);
    endtask

    initial begin
        int r;
        int g_frozen;
        int ok;
        bus.ena = 1'b1; bus.sample_en = 1'b0; bus.dry = '0; bus.taps = '0;
        bus.tap_sel = '0; bus.mix_gain = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_y",          int'(bus.y),          0);
        check("rst_y_valid",    int'(bus.y_valid),    0);
        check("rst_busy",       int'(bus.busy),       0);
        check("rst_active_tap", int'(bus.active_tap), 0);
        rst_n = 1'b1;
        tick();

        // 1: gain 0 -> pure dry, latency 2
        bus.dry  = 8'd100;
        bus.taps = {4{8'd200}};
        repeat (3) begin
            bus.sample_en = 1'b1;
            tick();
            bus.sample_en = 1'b0;
            check("t1_vld_early", int'(bus.y_valid), 0);
            tick();
            check("t1_vld", int'(bus.y_valid), 1);
            check("t1_y",   int'(bus.y),       100);
            tick();
            check("t1_vld_drop", int'(bus.y_valid), 0);
            check("t1_y_hold",   int'(bus.y),       100);
        end
        check("t1_tap", int'(bus.active_tap), 0);

        // 2: ramp to 8 then 15
        bus.mix_gain = 4'd8;
        strobes(8);
        check("t2_g8", m_g, 8);
        measure("t2_y150", 150);
        bus.mix_gain = 4'd15;
        bus.dry  = 8'd0;
        bus.taps = {4{8'd255}};
        strobes(7);
        check("t2_g15", m_g, 15);
        measure("t2_y239", 239);

        // 3: settled at 8, crossfade 0 -> 2
        bus.mix_gain = 4'd8;
        strobes(7);
        check("t3_g8", m_g, 8);
        bus.dry  = 8'd100;
        bus.taps = {8'd40, 8'd30, 8'd250, 8'd200};
        bus.tap_sel = 2'd2;
        run_fade("t3", -1, 0, r);
        check("t3_rises", r, 1);
        check("t3_tap",   int'(bus.active_tap), 2);
        check("t3_g",     m_g, 8);
        measure("t3_y", (100 * 8 + 30 * 8 + 8) / 16);

        // 4: request changes 2->3->1 mid fade-out, single crossfade
        bus.tap_sel = 2'd3;
        run_fade("t4", 2, 1, r);
        check("t4_rises", r, 1);
        check("t4_tap",   int'(bus.active_tap), 1);

        // 5: ena low mid fade-in freezes the ramp and mutes the output
        bus.tap_sel = 2'd0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            bus.sample_en = 1'(($urandom % 2) != 0);
            tick();
            if (m_phase == PH_IN && m_g >= 3) begin
                ok = 1;
                break;
            end
        end
        check("t5_reached_fade_in", ok, 1);
        bus.ena  = 1'b0;
        g_frozen = m_g;
        for (int i = 0; i < 10; i++) begin
            bus.sample_en = 1'(($urandom % 2) != 0);
            tick();
        end
        check("t5_y_muted",   int'(bus.y),       0);
        check("t5_vld_muted", int'(bus.y_valid), 0);
        check("t5_busy_held", int'(bus.busy),    1);
        check("t5_g_frozen",  m_g,               g_frozen);
        bus.ena = 1'b1;
        run_fade("t5", -1, 0, r);
        check("t5_tap", int'(bus.active_tap), 0);

        // 6: asynchronous reset mid fade-out
        bus.tap_sel = 2'd3;
        tick();
        strobes(3);
        check("t6_in_fade_out", m_phase, PH_OUT);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", int'(bus.busy),       0);
        check("t6_rst_tap",  int'(bus.active_tap), 0);
        check("t6_rst_y",    int'(bus.y),          0);
        check("t6_rst_vld",  int'(bus.y_valid),    0);
        bus.tap_sel = 2'd0;
        bus.dry     = 8'd77;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_busy", int'(bus.busy),       0);
        check("t6_tap",  int'(bus.active_tap), 0);
        measure("t6_first_y", 77);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bus.ena       = 1'(($urandom % 16) != 0);
            bus.sample_en = 1'(($urandom % 2) != 0);
            bus.dry       = 8'($urandom);
            bus.taps      = 32'($urandom);
            if (($urandom % 60) == 0) bus.tap_sel  = 2'($urandom_range(3));
            if (($urandom % 25) == 0) bus.mix_gain = 4'($urandom_range(15));
            tick();
        end
        bus.ena = 1'b1;
        bus.sample_en = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
